// File: rtl/alu_pkg.sv
// Shared ALU op codes and arbiter FSM state type for the alu_arbiter slice.
// Also provides a small helper that turns a two-bit one-hot grant into a port index.
package alu_pkg;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    localparam int unsigned NumPorts = 2;
    localparam int unsigned OpWidth  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    // Index of the granted port; only bit 1 matters for a valid one-hot grant.
    function automatic logic grant_index(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin grant: a lone requester wins, on contention the port
// that was not served last wins. Output is one-hot, or zero when disabled.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two request/response ports.
// Each operation runs IDLE (accept) -> EXEC (drive ALU, capture) -> RESP (hold until taken).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [7:0]           req_op,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_zero,
    output logic [3:0]           alu_control,
    output logic [WIDTH-1:0]     alu_in1,
    output logic [WIDTH-1:0]     alu_in2,
    input  logic [WIDTH-1:0]     alu_out
);

    state_e             state_q, state_d;
    logic               last_grant_q;
    logic               gnt_idx_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_zero_q;

    logic [1:0]         gnt;
    logic               arb_en;
    logic               accept;
    logic               gnt_idx;
    logic               retire;
    logic [3:0]         sel_op;
    logic [WIDTH-1:0]   sel_a, sel_b;

    assign arb_en = (state_q == StIdle);

    rr_arbiter2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .enable     (arb_en),
        .gnt        (gnt)
    );

    // The arbiter only grants requesting ports, so any grant is an accept.
    assign accept  = |gnt;
    assign gnt_idx = grant_index(gnt);
    assign retire  = (state_q == StResp) && rsp_ready[gnt_idx_q];

    assign sel_op = gnt_idx ? req_op[7:4]           : req_op[3:0];
    assign sel_a  = gnt_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b  = gnt_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        alu_control = 4'b0000;
        alu_in1     = '0;
        alu_in2     = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = gnt;
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_control = op_q;
                alu_in1     = a_q;
                alu_in2     = b_q;
                state_d     = StResp;
            end
            StResp: begin
                rsp_valid[gnt_idx_q] = 1'b1;
                if (retire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gnt_idx_q    <= 1'b0;
            op_q         <= 4'b0000;
            a_q          <= '0;
            b_q          <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && accept) begin
                gnt_idx_q <= gnt_idx;
                op_q      <= sel_op;
                a_q       <= sel_a;
                b_q       <= sel_b;
            end
            // Zero flag is derived here rather than trusted from the ALU.
            if (state_q == StExec) begin
                rsp_data_q <= alu_out;
                rsp_zero_q <= (alu_out == '0);
            end
            if (retire) begin
                last_grant_q <= gnt_idx_q;
            end
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_zero = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with an in-bench ALU and
// a transaction-level reference (grant rule + result arithmetic).
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [7:0]     req_op;
    logic [2*W-1:0] req_a, req_b;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_zero;
    logic [3:0]     alu_control;
    logic [W-1:0]   alu_in1, alu_in2, alu_out;

    int total    = 0;
    int pass_cnt = 0;
    logic last_m = 1'b1;

    always #5 clock = ~clock;

    alu_arbiter #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .alu_control (alu_control),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_out     (alu_out)
    );

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    // Environment ALU seen by the DUT.
    assign alu_out = ref_alu(alu_control, alu_in1, alu_in2);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // One full operation: present mask, predict the winner, follow it through EXEC and RESP.
    task automatic run_op(input logic [1:0] mask,
                          input logic [3:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [3:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input int stall);
        int p;
        logic [3:0]   op;
        logic [W-1:0] a, b, exp;
        logic [1:0]   onehot;
        if (mask == 2'b11) p = last_m ? 0 : 1;
        else               p = mask[1] ? 1 : 0;
        op     = p ? op1 : op0;
        a      = p ? a1 : a0;
        b      = p ? b1 : b0;
        exp    = ref_alu(op, a, b);
        onehot = (p == 1) ? 2'b10 : 2'b01;

        req_valid    = mask;
        req_op       = {op1, op0};
        req_a        = {a1, a0};
        req_b        = {b1, b0};
        rsp_ready[p] = (stall == 0);
        rsp_ready[1-p] = 1'b1;
        #1;
        check("idle_req_ready", W'(req_ready), W'(onehot));
        check("idle_alu_ctrl", W'(alu_control), '0);
        tick();
        check("exec_alu_ctrl", W'(alu_control), W'(op));
        check("exec_alu_in1", alu_in1, a);
        check("exec_alu_in2", alu_in2, b);
        check("exec_req_ready", W'(req_ready), '0);
        check("exec_rsp_valid", W'(rsp_valid), '0);
        tick();
        for (int i = 0; i < stall; i++) begin
            check("stall_rsp_valid", W'(rsp_valid), W'(onehot));
            check("stall_rsp_data", rsp_data, exp);
            check("stall_rsp_zero", W'(rsp_zero), W'(exp == '0));
            check("stall_req_ready", W'(req_ready), '0);
            tick();
        end
        if (stall > 0) begin
            rsp_ready[p] = 1'b1;
            #1;
        end
        check("resp_rsp_valid", W'(rsp_valid), W'(onehot));
        check("resp_rsp_data", rsp_data, exp);
        check("resp_rsp_zero", W'(rsp_zero), W'(exp == '0));
        check("resp_alu_in1", alu_in1, '0);
        tick();
        check("after_rsp_valid", W'(rsp_valid), '0);
        last_m = p[0];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, W'(req_ready), '0);
        check({tag, "_rsp_valid"}, W'(rsp_valid), '0);
        check({tag, "_rsp_data"}, rsp_data, '0);
        check({tag, "_rsp_zero"}, W'(rsp_zero), '0);
        check({tag, "_alu_ctrl"}, W'(alu_control), '0);
        check({tag, "_alu_in1"}, alu_in1, '0);
        check({tag, "_alu_in2"}, alu_in2, '0);
    endtask

    initial begin
        logic [3:0] ops [7];
        logic [3:0] o0, o1;
        logic [W-1:0] x0, y0, x1, y1;
        logic [1:0] m;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111};

        reset = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 2'b00;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check_all_zero("reset");
        tick();

        // Contention right after reset: port 0 first, then port 1.
        run_op(2'b11, 4'b0000, 32'hF0, 32'h3C, 4'b0110, 32'd9, 32'd9, 0);
        run_op(2'b11, 4'b0000, 32'hF0, 32'h3C, 4'b0110, 32'd9, 32'd9, 0);

        run_op(2'b01, 4'b0010, 32'd5, 32'd7, 4'b0000, '0, '0, 0);
        run_op(2'b10, 4'b0000, '0, '0, 4'b0111, 32'd3, 32'd8, 5);
        run_op(2'b01, 4'b1111, 32'd1, 32'd1, 4'b0000, '0, '0, 0);

        // Reset while an op sits in EXEC: discarded, everything back to zero.
        req_valid = 2'b01; req_op = {4'b0000, 4'b0010}; req_a = {32'd0, 32'd20};
        req_b = {32'd0, 32'd22}; rsp_ready = 2'b11;
        #1;
        tick();
        check("rst_exec_alu_ctrl", W'(alu_control), W'(4'b0010));
        reset = 1'b1; req_valid = 2'b00;
        tick();
        reset = 1'b0;
        #1;
        check_all_zero("rst_exec");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_rsp", W'(rsp_valid), '0);
        end
        last_m = 1'b1;

        // Back-to-back contention: strict alternation at three cycles per op.
        for (int i = 0; i < 6; i++) begin
            run_op(2'b11, 4'b0010, W'(i), 32'd100, 4'b0001, W'(i), 32'h1000, 0);
        end

        for (int i = 0; i < 24; i++) begin
            m  = 2'($urandom_range(1, 3));
            o0 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
            o1 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
            x0 = $urandom;
            y0 = ($urandom_range(0, 3) == 0) ? x0 : $urandom;
            x1 = $urandom;
            y1 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
            run_op(m, o0, x0, y0, o1, x1, y1, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
